// File: rtl/rv_wb_pkg.sv
// rv_wb shared types: write-back control, memory response,
// load size encoding and write-back FSM states.
package rv_wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4
    } t_ld_size;

    typedef enum logic [1:0] {
        WB_IDLE = ST_IDLE,
        WB_WAIT = ST_WAIT,
        WB_HOLD = ST_HOLD
    } t_wb_state;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic       rd_wr_en;
        logic [4:0] rd_addr;
        t_ld_size   ld_size;
        logic [1:0] addr_lsb;
    } t_wb_ctrl;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd_data;
    } t_mem2core_rsp;

endpackage

// File: rtl/rv_wb_if.sv
// rv_wb bus bundle: Q104H inputs, pipeline ready,
// register-file write port, Q105H bypass and error flags.
interface rv_wb_if;
    import rv_wb_pkg::*;

    t_wb_ctrl      ctrl;
    logic [31:0]   pre_wb_data_Q104H;
    t_mem2core_rsp dmem2core_rsp_Q104H;
    logic          ext_stall_Q104H;
    logic          ready_Q104H;
    logic          rf_wr_en_Q104H;
    logic [4:0]    rf_wr_addr_Q104H;
    logic [31:0]   rf_wr_data_Q104H;
    logic          fwd_wr_en_Q105H;
    logic [4:0]    fwd_wr_addr_Q105H;
    logic [31:0]   fwd_wr_data_Q105H;
    logic          timeout_err;
    logic          protocol_err;

    modport slave (
        input  ctrl, pre_wb_data_Q104H,
        input  dmem2core_rsp_Q104H, ext_stall_Q104H,
        output ready_Q104H,
        output rf_wr_en_Q104H, rf_wr_addr_Q104H,
        output rf_wr_data_Q104H,
        output fwd_wr_en_Q105H, fwd_wr_addr_Q105H,
        output fwd_wr_data_Q105H,
        output timeout_err, protocol_err
    );

    modport master (
        output ctrl, pre_wb_data_Q104H,
        output dmem2core_rsp_Q104H, ext_stall_Q104H,
        input  ready_Q104H,
        input  rf_wr_en_Q104H, rf_wr_addr_Q104H,
        input  rf_wr_data_Q104H,
        input  fwd_wr_en_Q105H, fwd_wr_addr_Q105H,
        input  fwd_wr_data_Q105H,
        input  timeout_err, protocol_err
    );

endinterface

// File: rtl/rv_wb_load_align.sv
// Load data aligner: selects byte/half/word by address
// offset and sign- or zero-extends to 32 bits.
module rv_load_align
    import rv_wb_pkg::*;
(
    input  logic [31:0] rd_data,
    input  t_ld_size    ld_size,
    input  logic [1:0]  addr_lsb,
    output logic [31:0] aligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // pick the lane, then extend according to load size
    always_comb begin
        byte_v  = rd_data[{addr_lsb, 3'b000} +: 8];
        half_v  = rd_data[{addr_lsb[1], 4'b0000} +: 16];
        aligned = rd_data;
        case (ld_size)
            LB:      aligned = {{24{byte_v[7]}}, byte_v};
            LBU:     aligned = {24'h0, byte_v};
            LH:      aligned = {{16{half_v[15]}}, half_v};
            LHU:     aligned = {16'h0, half_v};
            default: aligned = rd_data;
        endcase
    end

endmodule

// File: rtl/rv_wb.sv
// Write-back stage: load response wait/hold FSM, RF write
// port and registered Q105H forwarding copy.
module rv_wb
    import rv_wb_pkg::*;
#(
    parameter int MAX_WAIT_CYC = 16,
    parameter int WAIT_CNT_W   = 5
) (
    input logic     clk,
    input logic     rst,
    rv_wb_if.slave  bus
);

    t_wb_state             state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]           hold_data_q, hold_data_d;
    logic                  fwd_en_q, fwd_en_d;
    logic [4:0]            fwd_addr_q, fwd_addr_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic                  tmo_q, tmo_d;
    logic                  prot_q, prot_d;

    logic        ld_pend;
    logic        rsp_v;
    logic        ext_stall;
    logic        wb_stall;
    logic        ready;
    logic        commit;
    logic [31:0] wb_data;
    logic [31:0] ld_aligned;

    assign ld_pend   = bus.ctrl.valid & bus.ctrl.is_load;
    assign rsp_v     = bus.dmem2core_rsp_Q104H.valid;
    assign ext_stall = bus.ext_stall_Q104H;

    rv_load_align u_align (
        .rd_data  (bus.dmem2core_rsp_Q104H.rd_data),
        .ld_size  (bus.ctrl.ld_size),
        .addr_lsb (bus.ctrl.addr_lsb),
        .aligned  (ld_aligned)
    );

    // FSM next state, write-back data select, error tracking
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        hold_data_d = hold_data_q;
        tmo_d       = tmo_q;
        prot_d      = prot_q;
        wb_data     = bus.pre_wb_data_Q104H;
        wb_stall    = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (ld_pend) begin
                    if (rsp_v) begin
                        wb_data = ld_aligned;
                        if (ext_stall) begin
                            hold_data_d = ld_aligned;
                            state_d     = WB_HOLD;
                        end
                    end else begin
                        wb_stall   = 1'b1;
                        state_d    = WB_WAIT;
                        wait_cnt_d = WAIT_CNT_W'(1);
                    end
                end else if (rsp_v) begin
                    prot_d = 1'b1;
                end
            end
            WB_WAIT: begin
                if (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT_CYC))
                    tmo_d = 1'b1;
                if (rsp_v) begin
                    wb_data = ld_aligned;
                    if (ext_stall) begin
                        hold_data_d = ld_aligned;
                        state_d     = WB_HOLD;
                    end else begin
                        state_d = WB_IDLE;
                    end
                end else begin
                    wb_stall = 1'b1;
                    if (wait_cnt_q != {WAIT_CNT_W{1'b1}})
                        wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WB_HOLD: begin
                wb_data = hold_data_q;
                if (rsp_v)
                    prot_d = 1'b1;
                if (!ext_stall)
                    state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // pipeline advance, RF commit and bypass next values
    always_comb begin
        ready  = !rst & !wb_stall & !ext_stall;
        commit = ready & bus.ctrl.valid & bus.ctrl.rd_wr_en
               & (bus.ctrl.rd_addr != 5'd0);
        fwd_en_d   = commit;
        fwd_addr_d = bus.ctrl.rd_addr;
        fwd_data_d = wb_data;
    end

    // state, counters, hold buffer, bypass and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            wait_cnt_q  <= '0;
            hold_data_q <= '0;
            fwd_en_q    <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            tmo_q       <= 1'b0;
            prot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_data_q <= hold_data_d;
            fwd_en_q    <= fwd_en_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            tmo_q       <= tmo_d;
            prot_q      <= prot_d;
        end
    end

    assign bus.ready_Q104H       = ready;
    assign bus.rf_wr_en_Q104H    = commit;
    assign bus.rf_wr_addr_Q104H  = bus.ctrl.rd_addr;
    assign bus.rf_wr_data_Q104H  = wb_data;
    assign bus.fwd_wr_en_Q105H   = fwd_en_q;
    assign bus.fwd_wr_addr_Q105H = fwd_addr_q;
    assign bus.fwd_wr_data_Q105H = fwd_data_q;
    assign bus.timeout_err       = tmo_q;
    assign bus.protocol_err      = prot_q;

endmodule

// File: doc/rv_wb.md
Name: rv_wb

Overview:
Write-back stage (Q104H), directly downstream of the memory-access stage. It consumes the registered pre-write-back data and the data-memory read response. It aligns and sign/zero-extends load data, and stalls the pipeline through ready_Q104H while a load response is outstanding. It drives the register-file write port and a one-cycle registered write-back bypass (Q105H) used for hazard forwarding.

Parameters:
MAX_WAIT_CYC, 16, WAIT-state cycle count at which the sticky timeout error sets
WAIT_CNT_W, 5, width of the wait counter; must satisfy 2^WAIT_CNT_W > MAX_WAIT_CYC

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
ctrl  in  t_wb_ctrl  Q104H control: valid, is_load, rd_wr_en, rd_addr[4:0], ld_size (LB/LH/LW/LBU/LHU), addr_lsb[1:0]
pre_wb_data_Q104H  in  32  non-load write-back data from the memory-access stage
dmem2core_rsp_Q104H  in  t_mem2core_rsp  valid + rd_data[31:0]; read response for the load request issued in Q103H
ext_stall_Q104H  in  1  stall request from other pipeline sources (e.g. fetch miss)
ready_Q104H  out  1  pipeline advance enable, shared by all stages
rf_wr_en_Q104H  out  1  register-file write strobe
rf_wr_addr_Q104H  out  5  destination register
rf_wr_data_Q104H  out  32  write data
fwd_wr_en_Q105H  out  1  registered copy of the last committed write
fwd_wr_addr_Q105H  out  5  registered copy of the last committed address
fwd_wr_data_Q105H  out  32  registered copy of the last committed data
timeout_err  out  1  sticky: load response not received within MAX_WAIT_CYC
protocol_err  out  1  sticky: response valid with no load waiting for it

Behaviour:
- States: IDLE, WAIT, HOLD. Reset gives IDLE, wait_cnt=0, hold_data=0, fwd_*=0, timeout_err=0, protocol_err=0. While rst is high, rf_wr_en_Q104H=0 and ready_Q104H=0.
- ld_pend = ctrl.valid & ctrl.is_load. rsp_v = dmem2core_rsp_Q104H.valid.
- IDLE, non-load: wb_data = pre_wb_data_Q104H, wb_stall=0. Zero added latency.
- IDLE, ld_pend & rsp_v: wb_data = align(rsp.rd_data).
  - If ext_stall_Q104H=1: capture aligned data into hold_data, go HOLD.
  - Otherwise commit this cycle and stay IDLE.
- IDLE, ld_pend & !rsp_v: wb_stall=1, go WAIT, wait_cnt=1.
- WAIT: wb_stall=1 until rsp_v. wait_cnt increments each cycle and saturates at all-ones. When wait_cnt==MAX_WAIT_CYC, timeout_err sets. The block keeps waiting. On rsp_v, handle exactly as "IDLE with response".
- HOLD: wb_data = hold_data, wb_stall=0. When ext_stall_Q104H deasserts, commit and go IDLE. An rsp_v arriving in HOLD is ignored and sets protocol_err.
- rsp_v while IDLE with no ld_pend sets protocol_err. The response data is discarded.
- ready_Q104H = !rst & !wb_stall & !ext_stall_Q104H.
- Commit = ready_Q104H & ctrl.valid & ctrl.rd_wr_en & (rd_addr != 0).
  - rf_wr_en_Q104H = commit.
  - rf_wr_addr_Q104H = ctrl.rd_addr.
  - rf_wr_data_Q104H = wb_data.
- fwd_*_Q105H load from rf_wr_* every cycle. When commit=0, fwd_wr_en_Q105H loads 0.
- Alignment, with off = addr_lsb:
  - LB/LBU: byte at bits [8*off+7 : 8*off], sign-/zero-extended.
  - LH/LHU: half at bits [16*off[1]+15 : 16*off[1]], extended; off[0] is ignored (no misalign trap in this stage).
  - LW: rd_data unchanged; off is ignored.
- Reset mid-WAIT or mid-HOLD: state returns to IDLE. The pending load is dropped, and the flushed pipeline does not reissue it.

Decomposition:
- pkg: t_wb_ctrl, t_mem2core_rsp, t_ld_size enum (LB, LH, LW, LBU, LHU), t_wb_state enum.
- Sub-module rv_load_align: purely combinational (rd_data, ld_size, addr_lsb) -> 32-bit aligned data. Verified standalone.

Test Plan:
- ALU result: non-load, rd=5, pre_wb=0x1234_5678, no stall -> same cycle rf_wr_en=1, addr 5, data 0x1234_5678; next cycle fwd_* match; ready stays 1.
- Zero-latency load: LB, off=3, rsp valid with 0x80FF_FFFF -> rf_wr_data=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- Slow load: LH, off=2, rsp arrives 3 cycles late with 0xBEEF_0000 -> ready=0 for 3 cycles, rf_wr_en=0 throughout; commit on arrival cycle with data 0xFFFF_BEEF.
- Response under external stall: LW, rsp 0xCAFE_F00D in a cycle with ext_stall=1, ext_stall held 2 more cycles, rsp then deasserts -> commit 0xCAFE_F00D in the cycle ext_stall drops.
- Timeout and protocol errors: load with no response for 20 cycles -> timeout_err rises at WAIT cycle 16 and stays set. Separately, rsp_v with no load pending -> protocol_err=1 and no rf write. Reset clears both.
- rd=0 and reset in WAIT: load to x0 -> no rf_wr_en. Assert rst during WAIT -> IDLE next cycle, no commit, ready=1 once rst drops.
